superscalar_queue: RTL and testbench
====================================

# superscalar_queue

Parametrised multi-lane circular FIFO that succeeds the single-lane instruction queue between fetch and decode/rename. Each cycle it accepts up to ENQ_WIDTH entries and releases up to DEQ_WIDTH entries, in order. It exposes occupancy, free-space and almost-full status for fetch throttling. A single-cycle flush on branch mispredict empties it.

## Interface
- DATA_WIDTH, 32, bits per entry.
- QUEUE_DEPTH, INST_QUEUE_DEPTH, number of entries; power of two, ≥ max(ENQ_WIDTH, DEQ_WIDTH), ≥ 2.
- ENQ_WIDTH, 2, enqueue lanes per cycle.
- DEQ_WIDTH, 2, dequeue lanes per cycle.
- AFULL_THRESH, QUEUE_DEPTH-ENQ_WIDTH, count at or above which almost_full_out asserts.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- wdata_in  in  ENQ_WIDTH×DATA_WIDTH  enqueue data; lane 0 oldest.
- enqueue_count_in  in  clog2(ENQ_WIDTH+1)  number of lanes (0..ENQ_WIDTH, from lane 0) to push.
- enqueue_ready_out  out  1  push of enqueue_count_in accepted this cycle.
- rdata_out  out  DEQ_WIDTH×DATA_WIDTH  head entries; lane 0 = oldest.
- rvalid_out  out  DEQ_WIDTH  lane i valid iff count > i.
- dequeue_count_in  in  clog2(DEQ_WIDTH+1)  number of head lanes consumed.
- count_out  out  clog2(QUEUE_DEPTH)+1  occupied entries.
- free_out  out  clog2(QUEUE_DEPTH)+1  QUEUE_DEPTH − count.
- full_out, empty_out, almost_full_out  out  1  status.
- global_branch_signal  in  1  flush.

## Operation
- Head/tail pointers: ADDR_WIDTH+1 bits, extra bit is wrap. count = tail − head (modulo 2^(ADDR_WIDTH+1)).
- Reset (rst=0, async): head=tail=0. Outputs: count_out=0, free_out=QUEUE_DEPTH, empty_out=1, full_out=0, almost_full_out=0, rvalid_out=0, enqueue_ready_out=1, rdata_out=0. Storage is not reset.
- Enqueue is all-or-nothing. enqueue_ready_out = (free ≥ enqueue_count_in) and not global_branch_signal.
  - When ready, lanes 0..n−1 are written at tail..tail+n−1, wrapping modulo depth, and tail advances by n.
  - When not ready, nothing is written.
- Dequeue: the effective count is min(dequeue_count_in, count); an over-request is clipped, not an error. Head advances by the effective count.
- Free space is judged on start-of-cycle state only. A same-cycle dequeue does not make room for the same-cycle enqueue.
- There is no bypass: an entry enqueued into an empty queue first appears on rdata_out the next cycle.
- rdata_out lane i = mem[head+i]. It is forced to 0 when rvalid_out[i]=0.
- Flush (global_branch_signal=1): head=tail=0 next cycle. Flush overrides same-cycle enqueue and dequeue; no writes occur.
- Simultaneous enqueue and dequeue at full is legal: enqueue is refused, dequeue proceeds.
- Status outputs are derived combinationally from registered head/tail (current state, not next state).

## Timing
- Enqueue-to-visible latency: 1 cycle.
- Dequeue takes effect at the clock edge; the next head lanes appear in the following cycle.
- enqueue_ready_out is combinational from enqueue_count_in and registered state. There is no path from dequeue_count_in to enqueue_ready_out.
- Flush: the queue reads empty in the cycle after the assertion.
- Reset asserted mid-operation clears pointers immediately (asynchronous). Outputs hold reset values until the first edge after rst deasserts.

## Structure
- Shared package rv32i_types holds INST_QUEUE_DEPTH, INST_QUEUE_ENQ_WIDTH and INST_QUEUE_DEQ_WIDTH.
- The entry type (instruction, PC) stays in the same package.
- No sub-module. Pointer arithmetic and the lane write/read muxes are generate loops inside superscalar_queue.
- An assertion block checks:
  - count ≤ QUEUE_DEPTH;
  - enqueue_count_in ≤ ENQ_WIDTH;
  - dequeue_count_in ≤ DEQ_WIDTH.

## Test plan
Configuration for all scenarios: DEPTH=8, ENQ=2, DEQ=2, DATA_WIDTH=32.
- Reset then idle → count_out=0, empty_out=1, rvalid_out=2'b00, free_out=8, rdata_out=0.
- Enqueue 2 per cycle for 4 cycles with A..H → count 2,4,6,8; full_out=1; almost_full_out=1 at count 6; a 5th push of 1 gives enqueue_ready_out=0 and count stays 8.
- Queue at count 7, enqueue_count_in=2 with dequeue_count_in=2 → enqueue refused; count becomes 5; order preserved.
- Wrap-around: fill 6, drain 6, push 4 → entries written at indices 6,7,0,1; rdata_out lanes return them in order.
- Count=1 (X), dequeue_count_in=2 → rvalid_out=2'b01, count becomes 0, empty_out=1.
- Count=5 with enqueue 2 and flush in the same cycle → next cycle count=0, free_out=8; pushed data never appears. Asynchronous reset pulsed mid-burst → outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/superscalar_queue_pkg.sv
// rv32i_types: shared front-end sizing for the instruction queue and its entry type.
package rv32i_types;
    localparam int INST_QUEUE_DEPTH     = 8;
    localparam int INST_QUEUE_ENQ_WIDTH = 2;
    localparam int INST_QUEUE_DEQ_WIDTH = 2;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;
endpackage

// File: rtl/superscalar_queue_if.sv
// superscalar_queue_if: enqueue/dequeue lanes and status bus of the instruction queue.
interface superscalar_queue_if
    import rv32i_types::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = INST_QUEUE_DEPTH,
    parameter int ENQ_WIDTH   = INST_QUEUE_ENQ_WIDTH,
    parameter int DEQ_WIDTH   = INST_QUEUE_DEQ_WIDTH
);
    localparam int EW = $clog2(ENQ_WIDTH + 1);
    localparam int DW = $clog2(DEQ_WIDTH + 1);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0] wdata_in;
    logic [EW-1:0]                        enqueue_count_in;
    logic                                 enqueue_ready_out;
    logic [DEQ_WIDTH-1:0][DATA_WIDTH-1:0] rdata_out;
    logic [DEQ_WIDTH-1:0]                 rvalid_out;
    logic [DW-1:0]                        dequeue_count_in;
    logic [CW-1:0]                        count_out;
    logic [CW-1:0]                        free_out;
    logic                                 full_out;
    logic                                 empty_out;
    logic                                 almost_full_out;
    modport master (
        output wdata_in, enqueue_count_in, dequeue_count_in,
        input  enqueue_ready_out, rdata_out, rvalid_out, count_out, free_out,
               full_out, empty_out, almost_full_out
    );
    modport slave (
        input  wdata_in, enqueue_count_in, dequeue_count_in,
        output enqueue_ready_out, rdata_out, rvalid_out, count_out, free_out,
               full_out, empty_out, almost_full_out
    );
endinterface

// File: rtl/superscalar_queue.sv
// superscalar_queue: multi-lane circular FIFO between fetch and decode with all-or-nothing
// enqueue, clipped dequeue, occupancy status and single-cycle flush.
module superscalar_queue
    import rv32i_types::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int QUEUE_DEPTH  = INST_QUEUE_DEPTH,
    parameter int ENQ_WIDTH    = INST_QUEUE_ENQ_WIDTH,
    parameter int DEQ_WIDTH    = INST_QUEUE_DEQ_WIDTH,
    parameter int AFULL_THRESH = QUEUE_DEPTH - ENQ_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               global_branch_signal,
    superscalar_queue_if.slave q
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         head_q, tail_q, head_d, tail_d;
    logic [PW-1:0]         count, enq_n, deq_n, deq_eff;
    logic                  enq_ok;
    logic [DATA_WIDTH-1:0] mem_q [QUEUE_DEPTH];
    logic [ENQ_WIDTH-1:0]  wr_en;
    logic [AW-1:0]         wr_addr [ENQ_WIDTH];

    assign count   = tail_q - head_q;
    assign enq_n   = PW'(q.enqueue_count_in);
    assign deq_n   = PW'(q.dequeue_count_in);
    assign deq_eff = (deq_n < count) ? deq_n : count;
    // Room is judged on start-of-cycle occupancy only, so dequeue never feeds ready.
    assign enq_ok  = (q.free_out >= enq_n) && !global_branch_signal;
    assign head_d  = global_branch_signal ? '0 : head_q + deq_eff;
    assign tail_d  = global_branch_signal ? '0 : tail_q + (enq_ok ? enq_n : '0);

    assign q.enqueue_ready_out = enq_ok;
    assign q.count_out         = count;
    assign q.free_out          = PW'(QUEUE_DEPTH) - count;
    assign q.full_out          = count == PW'(QUEUE_DEPTH);
    assign q.empty_out         = count == '0;
    assign q.almost_full_out   = count >= PW'(AFULL_THRESH);

    for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_wr
        assign wr_en[i]   = enq_ok && (PW'(i) < enq_n);
        assign wr_addr[i] = tail_q[AW-1:0] + AW'(i);
    end

    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_rd
        assign q.rvalid_out[i] = count > PW'(i);
        assign q.rdata_out[i]  = q.rvalid_out[i] ? mem_q[head_q[AW-1:0] + AW'(i)] : '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++)
            if (wr_en[i]) mem_q[wr_addr[i]] <= q.wdata_in[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    a_count: assert property (@(posedge clk) disable iff (!rst) count <= PW'(QUEUE_DEPTH));
    a_enq:   assert property (@(posedge clk) disable iff (!rst) int'(q.enqueue_count_in) <= ENQ_WIDTH);
    a_deq:   assert property (@(posedge clk) disable iff (!rst) int'(q.dequeue_count_in) <= DEQ_WIDTH);
endmodule

// File: tb/tb_superscalar_queue.sv
// tb_superscalar_queue: scoreboard bench for superscalar_queue at depth 8, 2 enqueue / 2 dequeue lanes.
module tb_superscalar_queue;
    import rv32i_types::*;
    localparam int D  = INST_QUEUE_DEPTH;
    localparam int NE = INST_QUEUE_ENQ_WIDTH;
    localparam int ND = INST_QUEUE_DEQ_WIDTH;

    logic clk = 0;
    logic rst = 0;
    logic flush = 0;
    logic [31:0] sb [$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    superscalar_queue_if #(.DATA_WIDTH(32), .QUEUE_DEPTH(D), .ENQ_WIDTH(NE), .DEQ_WIDTH(ND)) bus ();
    superscalar_queue #(.DATA_WIDTH(32), .QUEUE_DEPTH(D), .ENQ_WIDTH(NE), .DEQ_WIDTH(ND)) dut (
        .clk(clk), .rst(rst), .global_branch_signal(flush), .q(bus)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(int n_enq);
        int c = sb.size();
        check("count", 64'(bus.count_out), 64'(c));
        check("free", 64'(bus.free_out), 64'(D - c));
        check("full", 64'(bus.full_out), 64'(c == D));
        check("empty", 64'(bus.empty_out), 64'(c == 0));
        check("afull", 64'(bus.almost_full_out), 64'(c >= D - NE));
        check("ready", 64'(bus.enqueue_ready_out), 64'((D - c) >= n_enq && !flush));
        for (int i = 0; i < ND; i++) begin
            logic [31:0] e = (c > i) ? sb[i] : 32'h0;
            check("rvalid", 64'(bus.rvalid_out[i]), 64'(c > i));
            check("rdata", 64'(bus.rdata_out[i]), 64'(e));
        end
    endtask

    // Drive one cycle from a negedge, check pre-edge outputs, then advance the scoreboard.
    task automatic step(int ne, int nd, logic fl, logic [31:0] d0, logic [31:0] d1);
        bit acc;
        int pops;
        bus.wdata_in[0] = d0;
        bus.wdata_in[1] = d1;
        bus.enqueue_count_in = 2'(ne);
        bus.dequeue_count_in = 2'(nd);
        flush = fl;
        #1;
        check_outputs(ne);
        acc = ((D - sb.size()) >= ne) && !fl;
        pops = (nd < sb.size()) ? nd : sb.size();
        @(posedge clk);
        if (fl) sb.delete();
        else begin
            repeat (pops) void'(sb.pop_front());
            if (acc && ne > 0) sb.push_back(d0);
            if (acc && ne > 1) sb.push_back(d1);
        end
        @(negedge clk);
        flush = 0;
    endtask

    initial begin
        bus.wdata_in = '0;
        bus.enqueue_count_in = '0;
        bus.dequeue_count_in = '0;
        #1;
        check_outputs(0);
        @(negedge clk);
        rst = 1;
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            step(2, 0, 0, 32'hA0 + 32'(2 * k), 32'hA1 + 32'(2 * k));
        step(1, 0, 0, 32'hEE, 0);
        step(0, 1, 0, 0, 0);
        step(2, 2, 0, 32'hB0, 32'hB1);
        for (int k = 0; k < 3; k++) step(0, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(2, 0, 0, 32'hC0 + 32'(2 * k), 32'hC1 + 32'(2 * k));
        for (int k = 0; k < 3; k++) step(0, 2, 0, 0, 0);
        step(2, 0, 0, 32'hD0, 32'hD1);
        step(2, 0, 0, 32'hD2, 32'hD3);
        step(0, 1, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 32'h58, 0);
        step(0, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) step(2, 0, 0, 32'hE0 + 32'(2 * k), 32'hE1 + 32'(2 * k));
        step(1, 0, 0, 32'hE4, 0);
        step(2, 0, 1, 32'hF0, 32'hF1);
        step(0, 0, 0, 0, 0);
        step(2, 0, 0, 32'h11, 32'h22);
        step(2, 1, 0, 32'h33, 32'h44);
        bus.enqueue_count_in = 2'd2;
        bus.dequeue_count_in = 2'd0;
        #2 rst = 0;
        sb.delete();
        #1;
        check_outputs(2);
        @(posedge clk);
        #1;
        check_outputs(2);
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 200; k++)
            step($urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 15) == 0),
                 $urandom, $urandom);
        step(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
